atm_session_ctrl: RTL and testbench



---
 rtl/atm_session_ctrl.sv | 124 ++++++++++++
 tb/tb_atm_session_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// Card/PIN session front-end: card insertion, language choice, PIN entry with
// lockout after repeated wrong PINs, and an inactivity timeout toward MainModule.
module atm_session_ctrl #(
  parameter logic [3:0] CORRECT_PIN    = 4'b1101,
  parameter int         MAX_TRIES      = 3,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Card_in,
  input  logic       Language_chosen,
  input  logic [3:0] Pin,
  input  logic       pin_valid,
  input  logic       leave,
  input  logic       activity,
  output logic       auth_ok,
  output logic       Timer,
  output logic       eject,
  output logic       card_retained,
  output logic [1:0] tries_left,
  output logic [2:0] state
);

  localparam logic [1:0] TRIES_INIT = MAX_TRIES[1:0];
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LANG   = 3'd1,
    S_PIN    = 3'd2,
    S_AUTH   = 3'd3,
    S_EJECT  = 3'd4,
    S_LOCKED = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] tries_q, tries_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timer_d;
  logic       counted, clear_in, timeout;

  // Next-state decode; card removal outranks PIN entry, which outranks
  // timeout, which outranks leave.
  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    timer_d  = 1'b0;
    counted  = (state_q == S_LANG) || (state_q == S_PIN) || (state_q == S_AUTH);
    clear_in = activity || pin_valid || leave ||
               (Language_chosen && (state_q == S_LANG));
    timeout  = counted && (cnt_q == IDLE_LIMIT) && !clear_in;

    case (state_q)
      S_IDLE: begin
        if (Card_in) begin
          state_d = S_LANG;
          tries_d = TRIES_INIT;
        end
      end
      S_LANG: begin
        if (!Card_in)             state_d = S_IDLE;
        else if (Language_chosen) state_d = S_PIN;
        else if (timeout) begin
          state_d = S_EJECT;
          timer_d = 1'b1;
        end
      end
      S_PIN: begin
        if (!Card_in) state_d = S_IDLE;
        else if (pin_valid) begin
          if (Pin == CORRECT_PIN) begin
            state_d = S_AUTH;
            tries_d = TRIES_INIT;
          end else begin
            tries_d = (tries_q == 2'd0) ? 2'd0 : tries_q - 2'd1;
            if (tries_q <= 2'd1) state_d = S_LOCKED;
          end
        end else if (timeout) begin
          state_d = S_EJECT;
          timer_d = 1'b1;
        end
      end
      S_AUTH: begin
        if (!Card_in) state_d = S_IDLE;
        else if (timeout) begin
          state_d = S_EJECT;
          timer_d = 1'b1;
        end else if (leave) state_d = S_EJECT;
      end
      S_EJECT, S_LOCKED: begin
        if (!Card_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) || clear_in || !counted) cnt_d = 8'd0;
    else                                              cnt_d = cnt_q + 8'd1;
  end

  // Flags are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tries_q       <= TRIES_INIT;
      cnt_q         <= 8'd0;
      auth_ok       <= 1'b0;
      Timer         <= 1'b0;
      eject         <= 1'b0;
      card_retained <= 1'b0;
    end else begin
      state_q       <= state_d;
      tries_q       <= tries_d;
      cnt_q         <= cnt_d;
      auth_ok       <= (state_d == S_AUTH);
      Timer         <= timer_d;
      eject         <= (state_d == S_EJECT);
      card_retained <= (state_d == S_LOCKED);
    end
  end

  assign tries_left = tries_q;
  assign state      = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed-vector bench for atm_session_ctrl with hand-computed expectations,
// followed by a short random run checking output invariants.
module tb_atm_session_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       Card_in, Language_chosen, pin_valid, leave, activity;
  logic [3:0] Pin;
  logic       auth_ok, Timer, eject, card_retained;
  logic [1:0] tries_left;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  atm_session_ctrl dut (
    .clk(clk), .rst(rst), .Card_in(Card_in), .Language_chosen(Language_chosen),
    .Pin(Pin), .pin_valid(pin_valid), .leave(leave), .activity(activity),
    .auth_ok(auth_ok), .Timer(Timer), .eject(eject), .card_retained(card_retained),
    .tries_left(tries_left), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle just past the edge.
  task automatic applyStimulus(input logic card, input logic lang, input logic [3:0] p,
                               input logic pv, input logic lv, input logic act);
    Card_in = card; Language_chosen = lang; Pin = p;
    pin_valid = pv; leave = lv; activity = act;
    @(posedge clk); #1;
  endtask

  task automatic checkAll(input string tag, input logic [2:0] st, input logic au,
                          input logic tm, input logic ej, input logic rt,
                          input logic [1:0] tr);
    checkOutput({tag, ".state"}, 8'(state), 8'(st));
    checkOutput({tag, ".auth_ok"}, 8'(auth_ok), 8'(au));
    checkOutput({tag, ".Timer"}, 8'(Timer), 8'(tm));
    checkOutput({tag, ".eject"}, 8'(eject), 8'(ej));
    checkOutput({tag, ".retained"}, 8'(card_retained), 8'(rt));
    checkOutput({tag, ".tries"}, 8'(tries_left), 8'(tr));
  endtask

  task automatic idleCycle(input logic card);
    applyStimulus(card, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkAll("reset", 3'd0, 0, 0, 0, 0, 2'd3);
    rst = 1'b0;

    // good path
    idleCycle(1'b1);
    checkAll("good.lang", 3'd1, 0, 0, 0, 0, 2'd3);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    checkAll("good.pin", 3'd2, 0, 0, 0, 0, 2'd3);
    applyStimulus(1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    checkAll("good.auth", 3'd3, 1, 0, 0, 0, 2'd3);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkAll("good.leave", 3'd4, 0, 0, 1, 0, 2'd3);
    idleCycle(1'b1);
    checkAll("good.hold", 3'd4, 0, 0, 1, 0, 2'd3);
    idleCycle(1'b0);
    checkAll("good.idle", 3'd0, 0, 0, 0, 0, 2'd3);

    // lockout
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
    checkAll("lock.1", 3'd2, 0, 0, 0, 0, 2'd2);
    applyStimulus(1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    checkAll("lock.2", 3'd2, 0, 0, 0, 0, 2'd1);
    applyStimulus(1'b1, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0);
    checkAll("lock.3", 3'd5, 0, 0, 0, 1, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    checkAll("lock.4", 3'd5, 0, 0, 0, 1, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    checkAll("lock.leave", 3'd5, 0, 0, 0, 1, 2'd0);
    idleCycle(1'b0);
    checkAll("lock.idle", 3'd0, 0, 0, 0, 0, 2'd0);

    // recovery, plus pin_valid in LANG ignored
    idleCycle(1'b1);
    checkAll("rec.lang", 3'd1, 0, 0, 0, 0, 2'd3);
    applyStimulus(1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    checkAll("rec.pvlang", 3'd1, 0, 0, 0, 0, 2'd3);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    checkAll("rec.w1", 3'd2, 0, 0, 0, 0, 2'd2);
    applyStimulus(1'b1, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0);
    checkAll("rec.w2", 3'd2, 0, 0, 0, 0, 2'd1);
    applyStimulus(1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    checkAll("rec.ok", 3'd3, 1, 0, 0, 0, 2'd3);

    // timeout in AUTH, entered on the edge above
    for (int i = 1; i <= 15; i++) begin
      idleCycle(1'b1);
      checkOutput("to.pre.Timer", 8'(Timer), 8'd0);
      checkOutput("to.pre.state", 8'(state), 8'd3);
    end
    idleCycle(1'b1);
    checkAll("to.fire", 3'd4, 0, 1, 1, 0, 2'd3);
    idleCycle(1'b1);
    checkAll("to.after", 3'd4, 0, 0, 1, 0, 2'd3);
    idleCycle(1'b0);

    // timeout restarted by activity on cycle 10
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    checkAll("act.auth", 3'd3, 1, 0, 0, 0, 2'd3);
    for (int i = 1; i <= 9; i++) idleCycle(1'b1);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("act.pulse.state", 8'(state), 8'd3);
    for (int i = 1; i <= 15; i++) begin
      idleCycle(1'b1);
      checkOutput("act.pre.Timer", 8'(Timer), 8'd0);
      checkOutput("act.pre.auth", 8'(auth_ok), 8'd1);
    end
    idleCycle(1'b1);
    checkAll("act.fire", 3'd4, 0, 1, 1, 0, 2'd3);
    idleCycle(1'b0);

    // correct PIN on the timeout cycle wins
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) idleCycle(1'b1);
    checkOutput("sim.pin.state", 8'(state), 8'd2);
    applyStimulus(1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    checkAll("sim.pin", 3'd3, 1, 0, 0, 0, 2'd3);
    idleCycle(1'b0);
    checkAll("sim.rm", 3'd0, 0, 0, 0, 0, 2'd3);

    // card removal coincident with correct PIN
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    checkAll("sim.card", 3'd0, 0, 0, 0, 0, 2'd3);

    // reset in LOCKED, then in AUTH
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 1'b0);
    checkAll("rst.locked", 3'd5, 0, 0, 0, 1, 2'd0);
    rst = 1'b1;
    idleCycle(1'b1);
    checkAll("rst.fromlock", 3'd0, 0, 0, 0, 0, 2'd3);
    rst = 1'b0;
    idleCycle(1'b1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    checkAll("rst.auth", 3'd3, 1, 0, 0, 0, 2'd3);
    rst = 1'b1;
    idleCycle(1'b1);
    checkAll("rst.fromauth", 3'd0, 0, 0, 0, 0, 2'd3);
    rst = 1'b0;

    // random run: output invariants
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(15) != 0, $urandom_range(3) == 0,
                    ($urandom_range(2) == 0) ? 4'b1101 : 4'($urandom_range(15)),
                    $urandom_range(5) == 0, $urandom_range(9) == 0,
                    $urandom_range(7) == 0);
      checkOutput("soak.excl", 8'($countones({auth_ok, eject, card_retained}) <= 1), 8'd1);
      checkOutput("soak.tries", 8'(tries_left <= 2'd3 && state <= 3'd5), 8'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
